// File: rtl/decode_buffer_pkg.sv
// Shared RV64 decode types and encoding constants for the decode buffer and
// its combinational decoder.
package instruction;

  typedef logic [31:0] inst_t;

  // M-extension members are appended so earlier encodings are unchanged.
  typedef enum logic [6:0] {
    NOP, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDIW, SLLIW, SRLIW, SRAIW,
    ADDW, SUBW, SLLW, SRLW, SRAW,
    ECALL, MRET,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    MULW, DIVW, DIVUW, REMW, REMUW
  } instruction_type;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [6:0] FUNCT7_ZERO   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [5:0] FUNCT6_SRAI   = 6'b010000;

  localparam inst_t INST_ECALL = 32'h0000_0073;
  localparam inst_t INST_MRET  = 32'h3020_0073;

endpackage

// File: rtl/decode_buffer_core.sv
// Combinational RV64I(+M) decoder: maps a raw word to an operation and flags
// every encoding that is not explicitly recognised as illegal.
module decode_core
  import instruction::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  inst_t           inst,
  output instruction_type op,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] f6;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];
  assign f6  = inst[31:26];

  always_comb begin
    op = NOP;
    case (opc)
      OPC_LUI:   op = LUI;
      OPC_AUIPC: op = AUIPC;
      OPC_JAL:   op = JAL;
      OPC_JALR:  if (f3 == 3'd0) op = JALR;
      BRANCH: begin
        case (f3)
          3'd0: op = BEQ;
          3'd1: op = BNE;
          3'd4: op = BLT;
          3'd5: op = BGE;
          3'd6: op = BLTU;
          3'd7: op = BGEU;
          default: ;
        endcase
      end
      LOAD: begin
        case (f3)
          3'd0: op = LB;
          3'd1: op = LH;
          3'd2: op = LW;
          3'd3: op = LD;
          3'd4: op = LBU;
          3'd5: op = LHU;
          3'd6: op = LWU;
          default: ;
        endcase
      end
      STORE: begin
        case (f3)
          3'd0: op = SB;
          3'd1: op = SH;
          3'd2: op = SW;
          3'd3: op = SD;
          default: ;
        endcase
      end
      OP_IMM: begin
        case (f3)
          3'd0: op = ADDI;
          3'd1: if (f6 == 6'd0) op = SLLI;
          3'd2: op = SLTI;
          3'd3: op = SLTIU;
          3'd4: op = XORI;
          3'd5: begin
            if (f6 == 6'd0) op = SRLI;
            else if (f6 == FUNCT6_SRAI) op = SRAI;
          end
          3'd6: op = ORI;
          3'd7: op = ANDI;
          default: ;
        endcase
      end
      OP_IMM_32: begin
        case (f3)
          3'd0: op = ADDIW;
          3'd1: if (f7 == FUNCT7_ZERO) op = SLLIW;
          3'd5: begin
            if (f7 == FUNCT7_ZERO) op = SRLIW;
            else if (f7 == FUNCT7_ALT) op = SRAIW;
          end
          default: ;
        endcase
      end
      OP: begin
        if (f7 == FUNCT7_ZERO) begin
          case (f3)
            3'd0: op = ADD;
            3'd1: op = SLL;
            3'd2: op = SLT;
            3'd3: op = SLTU;
            3'd4: op = XOR;
            3'd5: op = SRL;
            3'd6: op = OR;
            3'd7: op = AND;
            default: ;
          endcase
        end else if (f7 == FUNCT7_ALT) begin
          if (f3 == 3'd0) op = SUB;
          else if (f3 == 3'd5) op = SRA;
        end else if (ENABLE_M && f7 == FUNCT7_MULDIV) begin
          case (f3)
            3'd0: op = MUL;
            3'd1: op = MULH;
            3'd2: op = MULHSU;
            3'd3: op = MULHU;
            3'd4: op = DIV;
            3'd5: op = DIVU;
            3'd6: op = REM;
            3'd7: op = REMU;
            default: ;
          endcase
        end
      end
      OP_32: begin
        if (f7 == FUNCT7_ZERO) begin
          case (f3)
            3'd0: op = ADDW;
            3'd1: op = SLLW;
            3'd5: op = SRLW;
            default: ;
          endcase
        end else if (f7 == FUNCT7_ALT) begin
          if (f3 == 3'd0) op = SUBW;
          else if (f3 == 3'd5) op = SRAW;
        end else if (ENABLE_M && f7 == FUNCT7_MULDIV) begin
          case (f3)
            3'd0: op = MULW;
            3'd4: op = DIVW;
            3'd5: op = DIVUW;
            3'd6: op = REMW;
            3'd7: op = REMUW;
            default: ;
          endcase
        end
      end
      SYSTEM: begin
        case (f3)
          3'd0: begin
            if (inst == INST_ECALL) op = ECALL;
            else if (inst == INST_MRET) op = MRET;
          end
          3'd1: op = CSRRW;
          3'd2: op = CSRRS;
          3'd3: op = CSRRC;
          3'd5: op = CSRRWI;
          3'd6: op = CSRRSI;
          3'd7: op = CSRRCI;
          default: ;
        endcase
      end
      default: ;
    endcase
    // No legal encoding decodes to NOP, so NOP doubles as the illegal marker;
    // words with inst[1:0] != 11 never match an opcode above.
    illegal = (op == NOP);
  end

endmodule

// File: rtl/decode_buffer.sv
// Fetch-to-issue FIFO that decodes each instruction on enqueue and presents
// the stored decode, raw word and PC of the head entry.
module decode_buffer
  import instruction::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  inst_t                    in_inst,
  input  logic [63:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output instruction_type          out_op,
  output inst_t                    out_inst,
  output logic [63:0]              out_pc,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  instruction_type mem_op   [DEPTH];
  logic            mem_ill  [DEPTH];
  inst_t           mem_inst [DEPTH];
  logic [63:0]     mem_pc   [DEPTH];

  logic [PW-1:0]   wr_ptr, rd_ptr;
  instruction_type dec_op;
  logic            dec_ill;
  logic            enq, deq;

  decode_core #(.ENABLE_M(ENABLE_M)) u_decode (
    .inst    (in_inst),
    .op      (dec_op),
    .illegal (dec_ill)
  );

  assign in_ready  = (count < CNT_FULL);
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  // Head fields are masked while empty so reset shows NOP/zero without
  // clearing storage.
  assign out_op      = out_valid ? mem_op[rd_ptr]   : NOP;
  assign out_illegal = out_valid ? mem_ill[rd_ptr]  : 1'b0;
  assign out_inst    = out_valid ? mem_inst[rd_ptr] : '0;
  assign out_pc      = out_valid ? mem_pc[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_op[wr_ptr]   <= dec_op;
      mem_ill[wr_ptr]  <= dec_ill;
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
